// File: rtl/ahb_subordinate_mem_pkg.sv
// Shared AHB transfer types, responder FSM states and the byte-lane helper.
package ahb_subordinate_mem_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3,
        HSIZE_4W    = 3'd4,
        HSIZE_8W    = 3'd5,
        HSIZE_16W   = 3'd6,
        HSIZE_32W   = 3'd7
    } hsize_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ERR1 = 2'd2,
        S_ERR2 = 2'd3
    } ahb_sub_state_e;

    // Byte lanes touched by a transfer of 2**size bytes starting at lane 'lane'.
    // Only sizes up to a doubleword are meaningful; larger sizes are rejected
    // before the mask is ever used for a commit.
    function automatic logic [7:0] lane_mask(input logic [2:0] lane, input logic [2:0] size);
        logic [7:0] base;
        case (size)
            3'd0:    base = 8'h01;
            3'd1:    base = 8'h03;
            3'd2:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << lane;
    endfunction

endpackage

// File: rtl/ahb_subordinate_mem_array.sv
// Word-organised storage with per-byte write enables and a combinational read port.
module ahb_subordinate_mem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256,
    parameter int IDX_W      = $clog2(MEM_DEPTH)
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [IDX_W-1:0]        widx,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [IDX_W-1:0]        ridx,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Byte-granular write; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (wstrb[b]) mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/ahb_subordinate_mem.sv
// AHB5 memory responder: wait states, two-cycle ERROR, single-entry exclusive monitor.
module ahb_subordinate_mem
    import ahb_subordinate_mem_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_DEPTH     = 256,
    parameter int WAIT_STATES   = 0,
    parameter int HMASTER_WIDTH = 4,
    parameter int HPROT_WIDTH   = 4
) (
    input  logic                     hclk,
    input  logic                     hreset,
    input  logic                     hsel,
    input  logic [ADDR_WIDTH-1:0]    haddr,
    input  logic [1:0]               htrans,
    input  logic                     hwrite,
    input  logic [2:0]               hsize,
    input  logic [2:0]               hburst,
    input  logic                     hmastlock,
    input  logic                     hnonsec,
    input  logic [HPROT_WIDTH-1:0]   hprot,
    input  logic                     hexcl,
    input  logic [HMASTER_WIDTH-1:0] hmaster,
    input  logic [DATA_WIDTH-1:0]    hwdata,
    input  logic [DATA_WIDTH/8-1:0]  hwstrb,
    input  logic                     hready,
    output logic                     hreadyout,
    output logic                     hresp,
    output logic [DATA_WIDTH-1:0]    hrdata,
    output logic                     hexokay
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int BW     = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(MEM_DEPTH);

    ahb_sub_state_e           state, state_nxt;
    logic [3:0]               cnt, cnt_nxt;
    logic                     vld_p1, vld_nxt;
    logic [IDX_W-1:0]         idx_p1;
    logic                     write_p1, excl_p1;
    logic [STRB_W-1:0]        lmask_p1;
    logic [HMASTER_WIDTH-1:0] master_p1;
    logic                     mon_vld;
    logic [IDX_W-1:0]         mon_idx;
    logic [HMASTER_WIDTH-1:0] mon_master;

    logic [ADDR_WIDTH-1:0]    word_addr, amask;
    logic [2:0]               lane;
    logic                     acc, acc_err, final_dp, excl_match, commit;
    logic [DATA_WIDTH-1:0]    mem_rdata;
    logic                     unused_ok;

    assign unused_ok = ^{hburst, hmastlock, hnonsec, hprot};

    // Address phase decode
    assign word_addr  = haddr >> BW;
    assign amask      = (ADDR_WIDTH'(1) << hsize) - ADDR_WIDTH'(1);
    assign lane       = 3'(haddr[BW-1:0]);
    assign acc        = (state == S_IDLE || state == S_ERR2) && hsel && hready &&
                        (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
    assign acc_err    = (word_addr >= ADDR_WIDTH'(MEM_DEPTH)) || (hsize > 3'(BW)) ||
                        (|(haddr & amask));

    // Data phase: the final cycle of an OKAY transfer is S_IDLE with a phase pending
    assign final_dp   = (state == S_IDLE) && vld_p1;
    assign excl_match = mon_vld && (mon_idx == idx_p1) && (mon_master == master_p1);
    assign commit     = final_dp && write_p1 && (!excl_p1 || excl_match) && !hreset;
    assign hrdata     = (final_dp && !write_p1) ? mem_rdata : '0;
    assign hexokay    = final_dp && excl_p1 && (!write_p1 || excl_match);

    // Capture the accepted address phase for use in the following data phase.
    always_ff @(posedge hclk) begin
        if (acc) begin
            idx_p1    <= word_addr[IDX_W-1:0];
            write_p1  <= hwrite;
            excl_p1   <= hexcl;
            master_p1 <= hmaster;
            lmask_p1  <= STRB_W'(lane_mask(lane, hsize));
        end
    end

    // Control state: FSM, wait counter and pending-data-phase flag.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state  <= S_IDLE;
            cnt    <= 4'd0;
            vld_p1 <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            vld_p1 <= vld_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        vld_nxt   = vld_p1;
        hreadyout = 1'b1;
        hresp     = HRESP_OKAY;
        case (state)
            S_IDLE, S_ERR2: begin
                if (state == S_ERR2) hresp = HRESP_ERROR;
                vld_nxt   = 1'b0;
                state_nxt = S_IDLE;
                if (acc) begin
                    if (acc_err) begin
                        state_nxt = S_ERR1;
                    end else begin
                        vld_nxt = 1'b1;
                        if (WAIT_STATES > 0) begin
                            state_nxt = S_WAIT;
                            cnt_nxt   = 4'(WAIT_STATES - 1);
                        end
                    end
                end
            end
            S_WAIT: begin
                hreadyout = 1'b0;
                if (cnt == 4'd0) state_nxt = S_IDLE;
                else             cnt_nxt   = cnt - 4'd1;
            end
            S_ERR1: begin
                hreadyout = 1'b0;
                hresp     = HRESP_ERROR;
                state_nxt = S_ERR2;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Exclusive monitor: set by exclusive reads, cleared by any write that hits it.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            mon_vld <= 1'b0;
        end else if (final_dp) begin
            if (excl_p1 && !write_p1) begin
                mon_vld    <= 1'b1;
                mon_idx    <= idx_p1;
                mon_master <= master_p1;
            end else if (write_p1 && excl_p1 && excl_match) begin
                mon_vld <= 1'b0;
            end else if (write_p1 && !excl_p1 && idx_p1 == mon_idx) begin
                mon_vld <= 1'b0;
            end
        end
    end

    ahb_subordinate_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk   (hclk),
        .we    (commit),
        .widx  (idx_p1),
        .wstrb (hwstrb & lmask_p1),
        .wdata (hwdata),
        .ridx  (idx_p1),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_ahb_subordinate_mem.sv
// Self-checking bench: a zero-wait and a two-wait-state responder behind one driver.
module tb_ahb_subordinate_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsel_b, wsel;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic        hwrite, hexcl;
    logic [2:0]  hsize;
    logic [3:0]  hmaster, hwstrb;
    logic        sel0, sel2;
    logic        ro0, ro2, rs0, rs2, xo0, xo2;
    logic [31:0] rd0, rd2;
    logic        ro, rs, xo;
    logic [31:0] rd;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem_m [2][256];
    logic        mon_v [2];
    int unsigned mon_i [2];
    logic [3:0]  mon_m [2];

    int          g_nlow, e_nlow;
    logic        g_lresp, g_fresp, g_fex, e_err, e_ex;
    logic [31:0] g_frd, e_rd;

    always #5 clk = ~clk;

    assign sel0 = hsel_b & ~wsel;
    assign sel2 = hsel_b &  wsel;
    assign ro = wsel ? ro2 : ro0;
    assign rs = wsel ? rs2 : rs0;
    assign xo = wsel ? xo2 : xo0;
    assign rd = wsel ? rd2 : rd0;

    ahb_subordinate_mem #(.WAIT_STATES(0)) dut0 (
        .hclk(clk), .hreset(rst), .hsel(sel0), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(3'd0), .hmastlock(1'b0), .hnonsec(1'b0),
        .hprot(4'd3), .hexcl(hexcl), .hmaster(hmaster), .hwdata(hwdata), .hwstrb(hwstrb),
        .hready(ro0), .hreadyout(ro0), .hresp(rs0), .hrdata(rd0), .hexokay(xo0));

    ahb_subordinate_mem #(.WAIT_STATES(2)) dut2 (
        .hclk(clk), .hreset(rst), .hsel(sel2), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(3'd0), .hmastlock(1'b0), .hnonsec(1'b0),
        .hprot(4'd3), .hexcl(hexcl), .hmaster(hmaster), .hwdata(hwdata), .hwstrb(hwstrb),
        .hready(ro2), .hreadyout(ro2), .hresp(rs2), .hrdata(rd2), .hexokay(xo2));

    // Reference behaviour of one transfer, straight from the transfer rules.
    function automatic void model_xfer(input int w, input logic wr, input logic [31:0] addr,
                                       input logic [2:0] size, input logic ex, input logic [3:0] mst,
                                       input logic [31:0] wd, input logic [3:0] st,
                                       output logic err, output logic [31:0] rdat, output logic exok);
        int unsigned widx;
        int nb, off;
        widx = addr / 4;
        nb   = 1 << size;
        off  = int'(addr % 4);
        err  = (widx >= 256) || (size > 3'd2) || ((addr % nb) != 0);
        rdat = 32'h0;
        exok = 1'b0;
        if (err) return;
        if (!wr) begin
            rdat = mem_m[w][widx];
            if (ex) begin
                mon_v[w] = 1'b1; mon_i[w] = widx; mon_m[w] = mst; exok = 1'b1;
            end
            return;
        end
        if (ex) begin
            if (mon_v[w] && mon_i[w] == widx && mon_m[w] == mst) begin
                exok = 1'b1; mon_v[w] = 1'b0;
            end else begin
                return;
            end
        end else if (mon_v[w] && mon_i[w] == widx) begin
            mon_v[w] = 1'b0;
        end
        for (int b = 0; b < 4; b++)
            if (b >= off && b < off + nb && st[b]) mem_m[w][widx][8*b +: 8] = wd[8*b +: 8];
    endfunction

    // One non-pipelined transfer; reports the observed data-phase behaviour.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic ex, input logic [3:0] mst, input logic [31:0] wd, input logic [3:0] st,
                        output int nlow, output logic lresp, output logic fresp,
                        output logic [31:0] frd, output logic fex);
        int guard;
        @(negedge clk);
        hsel_b = 1'b1; haddr = addr; htrans = 2'd2; hwrite = wr; hsize = size;
        hexcl = ex; hmaster = mst;
        @(posedge clk);
        @(negedge clk);
        hsel_b = 1'b0; htrans = 2'd0; hwdata = wd; hwstrb = st;
        nlow = 0; lresp = 1'b0; guard = 0;
        while (ro !== 1'b1 && guard < 40) begin
            lresp = lresp | rs; nlow++; guard++;
            @(negedge clk);
        end
        if (guard >= 40) begin
            total++; bad++;
            $display("FAIL xfer_timeout addr=%h hreadyout stayed low for %0d cycles, want high", addr, guard);
        end
        fresp = rs; frd = rd; fex = xo;
        @(posedge clk);
    endtask

    task automatic op(input logic w, input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic ex, input logic [3:0] mst, input logic [31:0] wd, input logic [3:0] st);
        wsel = w;
        model_xfer(int'(w), wr, addr, size, ex, mst, wd, st, e_err, e_rd, e_ex);
        e_nlow = e_err ? 1 : (w ? 2 : 0);
        xfer(wr, addr, size, ex, mst, wd, st, g_nlow, g_lresp, g_fresp, g_frd, g_fex);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        total++; if ({ro0, rs0, xo0} !== 3'b100) begin bad++; $display("FAIL reset_ctl0 got=%b want=100", {ro0, rs0, xo0}); end
        total++; if (rd0 !== 32'h0) begin bad++; $display("FAIL reset_rdata0 got=%h want=0", rd0); end
        total++; if ({ro2, rs2, xo2} !== 3'b100) begin bad++; $display("FAIL reset_ctl2 got=%b want=100", {ro2, rs2, xo2}); end
        total++; if (rd2 !== 32'h0) begin bad++; $display("FAIL reset_rdata2 got=%h want=0", rd2); end
    endtask

    task automatic init_mem();
        for (int w = 0; w < 2; w++)
            for (int i = 0; i < 32; i++)
                op(1'(w), 1'b1, 32'(i * 4), 3'd2, 1'b0, 4'd1, $urandom, 4'hF);
    endtask

    task automatic test_zero_wait();
        op(1'b0, 1'b1, 32'h10, 3'd2, 1'b0, 4'd1, 32'hDEADBEEF, 4'hF);
        total++; if (g_nlow !== 0) begin bad++; $display("FAIL zw_wr_waits got=%0d want=0", g_nlow); end
        op(1'b0, 1'b0, 32'h10, 3'd2, 1'b0, 4'd1, 32'h0, 4'h0);
        total++; if (g_nlow !== 0) begin bad++; $display("FAIL zw_rd_waits got=%0d want=0", g_nlow); end
        total++; if (g_frd !== 32'hDEADBEEF) begin bad++; $display("FAIL zw_rdata got=%h want=deadbeef", g_frd); end
        total++; if (g_fresp !== 1'b0) begin bad++; $display("FAIL zw_resp got=%b want=0", g_fresp); end
    endtask

    task automatic test_wait_states();
        op(1'b1, 1'b1, 32'h40, 3'd2, 1'b0, 4'd1, 32'hCAFEF00D, 4'hF);
        op(1'b1, 1'b0, 32'h40, 3'd2, 1'b0, 4'd1, 32'h0, 4'h0);
        total++; if (g_nlow !== 2) begin bad++; $display("FAIL ws_low_cycles got=%0d want=2", g_nlow); end
        total++; if (g_lresp !== 1'b0 || g_fresp !== 1'b0) begin bad++; $display("FAIL ws_resp got=%b%b want=00", g_lresp, g_fresp); end
        total++; if (g_frd !== 32'hCAFEF00D) begin bad++; $display("FAIL ws_rdata got=%h want=cafef00d", g_frd); end
    endtask

    task automatic test_byte_write();
        op(1'b0, 1'b1, 32'h10, 3'd2, 1'b0, 4'd1, 32'h11223344, 4'hF);
        op(1'b0, 1'b1, 32'h13, 3'd0, 1'b0, 4'd1, 32'hAA000000, 4'b1000);
        op(1'b0, 1'b0, 32'h10, 3'd2, 1'b0, 4'd1, 32'h0, 4'h0);
        total++; if (g_frd !== 32'hAA223344) begin bad++; $display("FAIL byte_rdata got=%h want=aa223344", g_frd); end
    endtask

    task automatic test_errors();
        logic [31:0] old0;
        for (int w = 0; w < 2; w++) begin
            old0 = mem_m[w][0];
            op(1'(w), 1'b0, 32'h400, 3'd2, 1'b0, 4'd1, 32'h0, 4'h0);
            total++; if ({g_nlow == 1, g_lresp, g_fresp} !== 3'b111) begin bad++; $display("FAIL err_range_rd w=%0d got low=%0d resp=%b%b want low=1 resp=11", w, g_nlow, g_lresp, g_fresp); end
            op(1'(w), 1'b1, 32'h400, 3'd2, 1'b0, 4'd1, 32'h55555555, 4'hF);
            total++; if ({g_nlow == 1, g_lresp, g_fresp} !== 3'b111) begin bad++; $display("FAIL err_range_wr w=%0d got low=%0d resp=%b%b want low=1 resp=11", w, g_nlow, g_lresp, g_fresp); end
            op(1'(w), 1'b1, 32'h01, 3'd1, 1'b0, 4'd1, 32'hFFFFFFFF, 4'hF);
            total++; if ({g_nlow == 1, g_lresp, g_fresp} !== 3'b111) begin bad++; $display("FAIL err_align w=%0d got low=%0d resp=%b%b want low=1 resp=11", w, g_nlow, g_lresp, g_fresp); end
            op(1'(w), 1'b1, 32'h00, 3'd3, 1'b0, 4'd1, 32'hFFFFFFFF, 4'hF);
            total++; if ({g_nlow == 1, g_lresp, g_fresp} !== 3'b111) begin bad++; $display("FAIL err_size w=%0d got low=%0d resp=%b%b want low=1 resp=11", w, g_nlow, g_lresp, g_fresp); end
            op(1'(w), 1'b0, 32'h00, 3'd2, 1'b0, 4'd1, 32'h0, 4'h0);
            total++; if (g_frd !== old0) begin bad++; $display("FAIL err_mem_kept w=%0d got=%h want=%h", w, g_frd, old0); end
        end
    endtask

    task automatic test_exclusive();
        op(1'b1, 1'b0, 32'h20, 3'd2, 1'b1, 4'd3, 32'h0, 4'h0);
        total++; if (g_fex !== 1'b1) begin bad++; $display("FAIL ex_rd_okay got=%b want=1", g_fex); end
        op(1'b1, 1'b1, 32'h20, 3'd2, 1'b1, 4'd3, 32'h0BADF00D, 4'hF);
        total++; if (g_fex !== 1'b1) begin bad++; $display("FAIL ex_wr_okay got=%b want=1", g_fex); end
        op(1'b1, 1'b0, 32'h20, 3'd2, 1'b0, 4'd3, 32'h0, 4'h0);
        total++; if (g_frd !== 32'h0BADF00D) begin bad++; $display("FAIL ex_wr_commit got=%h want=0badf00d", g_frd); end
        op(1'b1, 1'b0, 32'h20, 3'd2, 1'b1, 4'd3, 32'h0, 4'h0);
        op(1'b1, 1'b1, 32'h20, 3'd2, 1'b0, 4'd1, 32'h12345678, 4'hF);
        op(1'b1, 1'b1, 32'h20, 3'd2, 1'b1, 4'd3, 32'h87654321, 4'hF);
        total++; if (g_fex !== 1'b0 || g_fresp !== 1'b0) begin bad++; $display("FAIL ex_wr_lost got exokay=%b resp=%b want 0 0", g_fex, g_fresp); end
        op(1'b1, 1'b0, 32'h20, 3'd2, 1'b0, 4'd3, 32'h0, 4'h0);
        total++; if (g_frd !== 32'h12345678) begin bad++; $display("FAIL ex_no_commit got=%h want=12345678", g_frd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, v;
        for (int k = 0; k < 3; k++) begin
            a = 32'($urandom_range(0, 31) * 4);
            v = $urandom;
            wsel = 1'b0;
            model_xfer(0, 1'b1, a, 3'd2, 1'b0, 4'd1, v, 4'hF, e_err, e_rd, e_ex);
            model_xfer(0, 1'b0, a, 3'd2, 1'b0, 4'd1, 32'h0, 4'h0, e_err, e_rd, e_ex);
            @(negedge clk);
            hsel_b = 1'b1; haddr = a; htrans = 2'd2; hwrite = 1'b1; hsize = 3'd2; hexcl = 1'b0; hmaster = 4'd1;
            @(posedge clk);
            @(negedge clk);
            hwdata = v; hwstrb = 4'hF; hwrite = 1'b0;
            total++; if (ro !== 1'b1) begin bad++; $display("FAIL b2b_wr_ready got=%b want=1", ro); end
            @(posedge clk);
            @(negedge clk);
            hsel_b = 1'b0; htrans = 2'd0;
            total++; if (ro !== 1'b1 || rd !== v || rd !== e_rd) begin bad++; $display("FAIL b2b_rdata got=%h ready=%b want=%h ready=1", rd, ro, v); end
            @(posedge clk);
        end
    endtask

    task automatic test_random();
        logic        w, wr, ex;
        logic [31:0] addr;
        logic [2:0]  size;
        for (int n = 0; n < 80; n++) begin
            w    = 1'($urandom_range(0, 1));
            wr   = 1'($urandom_range(0, 1));
            size = 3'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0)      addr = 32'h400 + $urandom_range(0, 255);
            else if ($urandom_range(0, 2) == 0) addr = 32'h20 + 32'($urandom_range(0, 1) * 4);
            else                                addr = $urandom_range(0, 127);
            if (size <= 3'd2 && $urandom_range(0, 9) < 7) addr = addr & ~((32'd1 << size) - 32'd1);
            ex = ($urandom_range(0, 2) == 0);
            op(w, wr, addr, size, ex, 4'($urandom_range(2, 3)), $urandom, 4'($urandom_range(0, 15)));
            total++; if (g_nlow !== e_nlow) begin bad++; $display("FAIL rnd_low n=%0d got=%0d want=%0d", n, g_nlow, e_nlow); end
            total++; if (g_lresp !== e_err || g_fresp !== e_err) begin bad++; $display("FAIL rnd_resp n=%0d got=%b%b want=%b%b", n, g_lresp, g_fresp, e_err, e_err); end
            total++; if (g_frd !== e_rd) begin bad++; $display("FAIL rnd_rdata n=%0d addr=%h got=%h want=%h", n, addr, g_frd, e_rd); end
            total++; if (g_fex !== e_ex) begin bad++; $display("FAIL rnd_exokay n=%0d got=%b want=%b", n, g_fex, e_ex); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] old;
        old  = mem_m[1][2];
        wsel = 1'b1;
        @(negedge clk);
        hsel_b = 1'b1; haddr = 32'h08; htrans = 2'd2; hwrite = 1'b1; hsize = 3'd2; hexcl = 1'b0; hmaster = 4'd1;
        @(posedge clk);
        @(negedge clk);
        hsel_b = 1'b0; htrans = 2'd0; hwdata = ~old; hwstrb = 4'hF;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mon_v[0] = 1'b0; mon_v[1] = 1'b0;
        total++; if ({ro2, rs2, xo2} !== 3'b100 || rd2 !== 32'h0) begin bad++; $display("FAIL rstmid_outputs got=%b rdata=%h want=100 rdata=0", {ro2, rs2, xo2}, rd2); end
        op(1'b1, 1'b0, 32'h08, 3'd2, 1'b0, 4'd1, 32'h0, 4'h0);
        total++; if (g_frd !== old) begin bad++; $display("FAIL rstmid_mem got=%h want=%h", g_frd, old); end
    endtask

    initial begin
        rst = 1'b1; hsel_b = 1'b0; wsel = 1'b0; haddr = '0; htrans = 2'd0; hwrite = 1'b0;
        hsize = 3'd2; hexcl = 1'b0; hmaster = 4'd0; hwdata = '0; hwstrb = 4'h0;
        mon_v[0] = 1'b0; mon_v[1] = 1'b0;
        test_reset();
        init_mem();
        test_zero_wait();
        test_wait_states();
        test_byte_write();
        test_errors();
        test_exclusive();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
